// File: rtl/uart_imem_loader.sv
// uart_imem_loader: receives a framed program image over UART and writes it into instruction RAM
module uart_imem_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 6,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] F_IDLE = 3'd0, F_LEN = 3'd1, F_DATA = 3'd2, F_CSUM = 3'd3, F_ERR = 3'd4;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic          rx_s1, rx_s2, byte_valid, frame_err;
  logic [1:0]    rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [2:0]    f_st;
  logic [7:0]    n, csum, wcnt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]    bidx;
  logic [23:0]   word;
  // synchroniser idles high so reset release never looks like a start bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_st      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rxd;
      rx_s2      <= rx_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s2) rx_st <= RX_START;
        end
        RX_START: if (cnt == HALF) begin
          cnt     <= '0;
          bit_idx <= '0;
          rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == FULL) begin
          cnt     <= '0;
          shift   <= {rx_s2, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) rx_st <= RX_STOP;
        end
        default: if (cnt == FULL) begin
          byte_valid <= rx_s2;
          frame_err  <= !rx_s2;
          rx_st      <= RX_IDLE;
        end
      endcase
    end
  end
  // shift stays stable while byte_valid is high, so it doubles as the received byte
  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_st      <= F_IDLE;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      n         <= '0;
      csum      <= '0;
      wcnt      <= '0;
      addr      <= '0;
      bidx      <= '0;
      word      <= '0;
    end else begin
      imem_we <= 1'b0;
      if (frame_err && f_st != F_IDLE) f_st <= F_ERR;
      else case (f_st)
        F_IDLE: if (byte_valid && shift == SYNC_BYTE) begin
          f_st      <= F_LEN;
          cpu_hold  <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b0;
          csum      <= '0;
        end
        F_LEN: if (byte_valid) begin
          n    <= shift;
          addr <= '0;
          wcnt <= '0;
          bidx <= '0;
          f_st <= shift == 8'd0 ? F_CSUM : int'(shift) > 2 ** ADDR_W ? F_ERR : F_DATA;
        end
        F_DATA: if (byte_valid) begin
          word <= {word[15:0], shift};
          csum <= csum ^ shift;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            imem_we   <= 1'b1;
            imem_data <= {word, shift};
            imem_addr <= addr;
            addr      <= addr + 1'b1;
            wcnt      <= wcnt + 8'd1;
            if (wcnt + 8'd1 == n) f_st <= F_CSUM;
          end
        end
        F_CSUM: if (byte_valid) begin
          f_st      <= shift == csum ? F_IDLE : F_ERR;
          load_done <= shift == csum;
          cpu_hold  <= shift != csum;
        end
        default: begin
          load_err <= 1'b1;
          f_st     <= F_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed UART frames against the instruction-memory loader
module tb_uart_imem_loader;
  localparam int CPB = 16;
  logic        clk = 1'b0, resetn = 1'b0, rxd = 1'b1;
  logic        imem_we, cpu_hold, load_done, load_err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  int          total = 0, bad = 0, wr_n = 0;
  logic [5:0]  wa [16];
  logic [31:0] wd [16];
  logic        prev_we = 1'b0, dbl = 1'b0;
  uart_imem_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_data(imem_data), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (imem_we && prev_we) dbl <= 1'b1;
    if (imem_we && wr_n < 16) begin
      wa[wr_n] <= imem_addr;
      wd[wr_n] <= imem_data;
    end
    if (imem_we) wr_n <= wr_n + 1;
    prev_we <= imem_we;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tx(input logic [7:0] b, input logic stop_ok);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (stop_ok ? CPB : CPB / 2 + 4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask
  task automatic tx_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tx(w[8*i +: 8], 1'b1);
  endtask
  function automatic logic [7:0] xw(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
  function automatic logic [63:0] st();
    return 64'({cpu_hold, load_done, load_err});
  endfunction
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({imem_we, imem_addr, imem_data, cpu_hold, load_done, load_err}), 64'd0);
    resetn = 1'b1;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_status", st(), 64'b000);
    tx(8'h00, 1'b1);
    tx(8'hFF, 1'b1);
    chk("junk_status", st(), 64'b000);
    chk("junk_writes", 64'(wr_n), 64'd0);
    tx(8'hA5, 1'b1);
    chk("sync_hold", st(), 64'b100);
    tx(8'h02, 1'b1);
    tx_word(32'h12345678);
    tx_word(32'hDEADBEEF);
    chk("a_writes", 64'(wr_n), 64'd2);
    chk("a_addr0", 64'(wa[0]), 64'd0);
    chk("a_data0", 64'(wd[0]), 64'h12345678);
    chk("a_addr1", 64'(wa[1]), 64'd1);
    chk("a_data1", 64'(wd[1]), 64'hDEADBEEF);
    chk("a_hold_pre_csum", st(), 64'b100);
    tx(xw(32'h12345678) ^ xw(32'hDEADBEEF), 1'b1);
    chk("a_status", st(), 64'b010);
    tx(8'hA5, 1'b1);
    tx(8'h02, 1'b1);
    tx_word(32'h12345678);
    tx_word(32'hDEADBEEF);
    tx(8'h00, 1'b1);
    chk("b_writes", 64'(wr_n), 64'd4);
    chk("b_data3", 64'(wd[3]), 64'hDEADBEEF);
    chk("b_status", st(), 64'b101);
    tx(8'hA5, 1'b1);
    tx(8'h01, 1'b1);
    tx(8'h11, 1'b1);
    tx(8'h22, 1'b1);
    tx(8'h33, 1'b0);
    chk("c_frame_err", st(), 64'b101);
    tx(8'h44, 1'b1);
    chk("c_no_writes", 64'(wr_n), 64'd4);
    tx(8'hA5, 1'b1);
    tx(8'h01, 1'b1);
    tx_word(32'hCAFEF00D);
    tx(xw(32'hCAFEF00D), 1'b1);
    chk("c_recover_writes", 64'(wr_n), 64'd5);
    chk("c_recover_addr", 64'(wa[4]), 64'd0);
    chk("c_recover_data", 64'(wd[4]), 64'hCAFEF00D);
    chk("c_recover_status", st(), 64'b010);
    tx(8'hA5, 1'b1);
    tx(8'h00, 1'b1);
    tx(8'h00, 1'b1);
    chk("d_empty_writes", 64'(wr_n), 64'd5);
    chk("d_empty_status", st(), 64'b010);
    tx(8'hA5, 1'b1);
    tx(8'h41, 1'b1);
    chk("d_too_long", st(), 64'b101);
    tx(8'hA5, 1'b1);
    tx(8'h40, 1'b1);
    chk("d_max_len_hold", st(), 64'b100);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tx(8'hA5, 1'b1);
    tx(8'h02, 1'b1);
    tx_word(32'h0BADF00D);
    tx(8'h77, 1'b1);
    chk("e_partial_writes", 64'(wr_n), 64'd6);
    chk("e_partial_data", 64'(wd[5]), 64'h0BADF00D);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("e_reset_outputs", 64'({imem_we, imem_addr, imem_data, cpu_hold, load_done, load_err}), 64'd0);
    tx(8'hA5, 1'b1);
    tx(8'h01, 1'b1);
    tx_word(32'h600DC0DE);
    tx(xw(32'h600DC0DE), 1'b1);
    chk("e_reload_writes", 64'(wr_n), 64'd7);
    chk("e_reload_addr", 64'(wa[6]), 64'd0);
    chk("e_reload_data", 64'(wd[6]), 64'h600DC0DE);
    chk("e_reload_status", st(), 64'b010);
    chk("no_double_we", 64'(dbl), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
